// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub
//   Pipelined add/subtract unit. The operand width is cut into STAGES equal
//   slices; stage k sums slice k with a chain of 4-bit carry-look-ahead
//   groups and registers its carry-out for stage k+1. Unconsumed operand
//   slices travel with the carry, finished sum slices ride along so that all
//   slices leave the last stage together. Flags (cout, ovf, zero) are formed
//   in the last stage. One global advance signal stalls the whole pipe.
//
//   Optional build macro: CLA_ADDSUB_SAT_EN
//     defined   -> on signed overflow the result saturates to 0111..1 or
//                  1000..0; ovf still reports 1, zero is taken on the
//                  saturated value.
//     undefined -> the result wraps modulo 2^WIDTH.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int S    = WIDTH / STAGES;  // slice width
  localparam int NG   = S / 4;           // 4-bit CLA groups per slice
  localparam int LAST = STAGES - 1;

  // One slice of look-ahead groups. Returns {carry out, carry into MSB, sum}.
  function automatic logic [S+1:0] cla_slice(input logic [S-1:0] x,
                                             input logic [S-1:0] y,
                                             input logic         ci);
    logic [S:0]   c;
    logic [S-1:0] s;
    logic [3:0]   g;
    logic [3:0]   p;
    logic         cg;
    logic [3:0]   cl;
    c    = {(S+1){1'b0}};
    s    = {S{1'b0}};
    c[0] = ci;
    for (int grp = 0; grp < NG; grp++) begin
      g  = x[grp*4 +: 4] & y[grp*4 +: 4];
      p  = x[grp*4 +: 4] ^ y[grp*4 +: 4];
      cg = c[grp*4];
      cl[0] = cg;
      cl[1] = g[0] | (p[0] & cg);
      cl[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg);
      cl[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & cg);
      c[grp*4+1] = cl[1];
      c[grp*4+2] = cl[2];
      c[grp*4+3] = cl[3];
      c[grp*4+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                        | (p[3] & p[2] & p[1] & g[0])
                        | (p[3] & p[2] & p[1] & p[0] & cg);
      s[grp*4 +: 4] = p ^ cl;
    end
    return {c[S], c[S-1], s};
  endfunction

`ifdef CLA_ADDSUB_SAT_EN
  // Signed saturation bound selected by the sign of the overflowing operands.
  function automatic logic [WIDTH-1:0] sat_value(input logic neg);
    logic [WIDTH-1:0] v;
    if (neg) begin
      v = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      v = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return v;
  endfunction
`endif

  // Pipeline registers: entry k holds the result of stage k.
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             carry_q [STAGES];
  logic             carry_d [STAGES];
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             cout_q, cout_d;
  logic             ovf_q,  ovf_d;
  logic             zero_q, zero_d;

  // Stage inputs and combinational stage results.
  logic [WIDTH-1:0] src_a    [STAGES];
  logic [WIDTH-1:0] src_b    [STAGES];
  logic [WIDTH-1:0] src_s    [STAGES];
  logic             src_c    [STAGES];
  logic             src_v    [STAGES];
  logic [WIDTH-1:0] stg_sum  [STAGES];
  logic             stg_cout [STAGES];
  logic             stg_cmsb [STAGES];
  logic [S+1:0]     res;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout;
  logic             fin_ovf;
  logic             fin_zero;
  logic             adv;

  assign out_valid = valid_q[LAST];
  assign adv       = ~valid_q[LAST] | out_ready;
  assign in_ready  = adv;
  assign sum       = sum_q[LAST];
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Route each stage's inputs: the ports feed stage 0 (b inverted and the
  // carry forced to 1 for subtract), later stages read the previous register.
  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_s[0] = {WIDTH{1'b0}};
    src_c[0] = sub ? 1'b1 : cin;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = sum_q[k-1];
      src_c[k] = carry_q[k-1];
      src_v[k] = valid_q[k-1];
    end
  end

  // Each stage sums its own slice and merges it into the partial result.
  always_comb begin
    res = {(S+2){1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      res         = cla_slice(src_a[k][k*S +: S], src_b[k][k*S +: S], src_c[k]);
      stg_sum[k]  = src_s[k];
      stg_sum[k][k*S +: S] = res[S-1:0];
      stg_cout[k] = res[S+1];
      stg_cmsb[k] = res[S];
    end
  end

  // Last-stage flags, with optional saturation of the result.
  always_comb begin
    fin_cout = stg_cout[LAST];
    fin_ovf  = stg_cmsb[LAST] ^ stg_cout[LAST];
    fin_sum  = stg_sum[LAST];
`ifdef CLA_ADDSUB_SAT_EN
    if (fin_ovf) begin
      fin_sum = sat_value(src_a[LAST][WIDTH-1]);
    end else begin
      fin_sum = stg_sum[LAST];
    end
`endif
    fin_zero = ~|fin_sum;
  end

  // Next state: shift every stage on advance, otherwise hold everything.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      sum_d[k]   = sum_q[k];
      carry_d[k] = carry_q[k];
      valid_d[k] = valid_q[k];
    end
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_d[k]     = src_a[k];
        b_d[k]     = src_b[k];
        sum_d[k]   = stg_sum[k];
        carry_d[k] = stg_cout[k];
        valid_d[k] = src_v[k];
      end
      sum_d[LAST] = fin_sum;
      cout_d      = fin_cout;
      ovf_d       = fin_ovf;
      zero_d      = fin_zero;
    end else begin
      cout_d = cout_q;
    end
  end

  // Pipeline state registers with synchronous reset that drops all ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= {WIDTH{1'b0}};
        b_q[k]     <= {WIDTH{1'b0}};
        sum_q[k]   <= {WIDTH{1'b0}};
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
      end
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        carry_q[k] <= carry_d[k];
        valid_q[k] <= valid_d[k];
      end
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (WIDTH=64, STAGES=4).
// Honours CLA_ADDSUB_SAT_EN for the expected overflow results.
module tb_pipelined_cla_addsub;

  localparam int W  = 64;
  localparam int ST = 4;

`ifdef CLA_ADDSUB_SAT_EN
  localparam logic [63:0] EXP_POS_OVF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_NEG_OVF = 64'h8000_0000_0000_0000;
`else
  localparam logic [63:0] EXP_POS_OVF = 64'h8000_0000_0000_0000;
  localparam logic [63:0] EXP_NEG_OVF = 64'h7FFF_FFFF_FFFF_FFFF;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic          zero;

  int n_checks = 0;
  int n_errors = 0;

  pipelined_cla_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {zero, ovf, cout, sum}, built from plain 65-bit arithmetic.
  function automatic logic [66:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic s, input logic ci);
    logic [63:0] ye;
    logic [64:0] full;
    logic [63:0] r;
    logic        o;
    ye   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, ye} + {64'd0, (s ? 1'b1 : ci)};
    r    = full[63:0];
    o    = (x[63] == ye[63]) && (r[63] != x[63]);
`ifdef CLA_ADDSUB_SAT_EN
    if (o) r = x[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    return {(r == 64'd0), o, full[64], r};
  endfunction

  // One op into an empty pipe; checks latency and all result fields.
  task automatic run_op(input string tag, input logic [63:0] xa, input logic [63:0] xb,
                        input logic xs, input logic xc, input logic [63:0] es,
                        input logic ec, input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    a = xa; b = xb; sub = xs; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(ST));
    check_val({tag, "_sum"}, sum, es);
    check_val({tag, "_cout"}, 64'(cout), 64'(ec));
    check_val({tag, "_ovf"}, 64'(ovf), 64'(eo));
    check_val({tag, "_zero"}, 64'(zero), 64'(ez));
  endtask

  // Streamed ops with a scoreboard; directed mode stalls cycles 3..6.
  task automatic stream(input string tag, input int n, input bit rnd);
    logic [66:0] q[$];
    logic [66:0] e;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stalls = 0;
    bit held = 1'b0;
    logic [63:0] held_sum = 64'd0;
    while (got < n && cyc < 6000) begin
      @(negedge clk);
      if (held) begin
        check_val({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, "_hold_sum"}, sum, held_sum);
      end
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else     out_ready = !(cyc >= 3 && cyc <= 6);
      if (sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        if (rnd) begin
          a   = {$urandom, $urandom};
          b   = {$urandom, $urandom};
          sub = $urandom_range(0, 1) != 0;
          cin = $urandom_range(0, 1) != 0;
        end else begin
          a = 64'(sent); b = 64'(sent); sub = 1'b0; cin = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check_val({tag, "_in_ready"}, 64'(in_ready), 64'(!out_valid || out_ready));
      if (!in_ready) stalls++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_val({tag, "_unexpected_out"}, 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check_val({tag, "_sum"}, sum, e[63:0]);
          check_val({tag, "_cout"}, 64'(cout), 64'(e[64]));
          check_val({tag, "_ovf"}, 64'(ovf), 64'(e[65]));
          check_val({tag, "_zero"}, 64'(zero), 64'(e[66]));
          if (!rnd) check_val({tag, "_order"}, sum, 64'(2 * got));
        end
        got++;
      end
      held     = out_valid && !out_ready;
      held_sum = sum;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sub, cin));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check_val({tag, "_count"}, 64'(got), 64'(n));
    if (!rnd) check_val({tag, "_stall_seen"}, 64'(stalls > 0), 64'd1);
  endtask

  initial begin
    int bad;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 64'd0; b = 64'd0; cin = 1'b0; sub = 1'b0;

    // Reset held two cycles: outputs must read zero.
    @(negedge clk);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_sum", sum, 64'd0);
    @(negedge clk);
    check_val("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
    rst = 1'b0;

    run_op("add_small", 64'h5, 64'h3, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0);
    run_op("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0, 1'b1, 1'b0, 1'b1);
    run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           EXP_POS_OVF, 1'b0, 1'b1, 1'b0);
    run_op("sub_neg", 64'h10, 64'h20, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 1'b0);
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
           EXP_NEG_OVF, 1'b1, 1'b1, 1'b0);
    run_op("sub_zero", 64'h5, 64'h5, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
    run_op("cin_slice", 64'hFFFF_FFFF, 64'h0, 1'b0, 1'b1,
           64'h1_0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("sub_cin0", 64'h3, 64'h1, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0, 1'b0);

    stream("bp", 8, 1'b0);

    // Reset with three ops in flight: nothing may emerge afterwards.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 64'(i + 1); b = 64'h1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_out_valid", 64'(out_valid), 64'd0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check_val("midrst_no_stale", 64'(bad), 64'd0);
    run_op("after_rst", 64'h7, 64'h9, 1'b0, 1'b0, 64'h10, 1'b0, 1'b0, 1'b0);

    stream("rnd", 400, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
